// File: rtl/eth_type_classifier.sv
// eth_type_classifier
// Steers Ethernet frames from a split header/payload stream to one of M_COUNT
// ports based on EtherType. Frames with no enabled table match are consumed
// and dropped, and drop_frame pulses once for each of them. The payload path
// uses a two-deep skid (output register plus temp register) with a registered
// input ready. This keeps full throughput while keeping the ready path short.

module eth_type_classifier #(
  parameter int                    DATA_WIDTH   = 64,
  parameter bit                    KEEP_ENABLE  = (DATA_WIDTH > 8),
  parameter int                    KEEP_WIDTH   = (DATA_WIDTH / 8),
  parameter int                    M_COUNT      = 4,
  parameter logic [M_COUNT*16-1:0] MATCH_TYPE   = {16'h86DD, 16'h88F7, 16'h0806, 16'h0800},
  parameter logic [M_COUNT-1:0]    MATCH_ENABLE = {M_COUNT{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,

  output logic [M_COUNT-1:0]    m_eth_hdr_valid,
  input  logic [M_COUNT-1:0]    m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
  output logic [M_COUNT-1:0]    m_eth_payload_axis_tvalid,
  input  logic [M_COUNT-1:0]    m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,

  output logic                  busy,
  output logic                  drop_frame
);

  localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Header registers
  logic [SEL_W-1:0]      r_sel;
  logic [M_COUNT-1:0]    r_hdr_valid;
  logic [47:0]           r_dest_mac;
  logic [47:0]           r_src_mac;
  logic [15:0]           r_eth_type;
  logic                  r_s_hdr_ready;
  logic                  r_s_payload_tready;
  logic                  r_drop_frame;

  // Payload skid registers
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_tdata;
  logic [KEEP_WIDTH-1:0] r_out_tkeep;
  logic                  r_out_tlast;
  logic                  r_out_tuser;
  logic                  r_tmp_valid;
  logic [DATA_WIDTH-1:0] r_tmp_tdata;
  logic [KEEP_WIDTH-1:0] r_tmp_tkeep;
  logic                  r_tmp_tlast;
  logic                  r_tmp_tuser;

  // Combinational helpers
  logic [M_COUNT-1:0]    w_match;
  logic                  w_hit;
  logic [SEL_W-1:0]      w_hit_sel;
  logic                  w_hdr_fire;
  logic                  w_in_fire;
  logic                  w_fwd_fire;
  logic                  w_m_tready;
  logic [KEEP_WIDTH-1:0] w_in_tkeep;
  logic [M_COUNT-1:0]    w_hdr_valid_next;
  logic                  w_out_valid_next;
  logic                  w_tmp_valid_next;
  logic                  w_load_out_in;
  logic                  w_load_out_tmp;
  logic                  w_load_tmp_in;
  logic                  w_s_hdr_ready_next;
  logic                  w_s_payload_tready_next;

  // Per-entry EtherType comparators
  generate
    for (genvar gi = 0; gi < M_COUNT; gi++) begin : g_match
      assign w_match[gi] = MATCH_ENABLE[gi] && (s_eth_type == MATCH_TYPE[gi*16 +: 16]);
    end
  endgenerate

  // Priority encoder: the lowest matching index wins, so duplicate entries resolve low
  always_comb begin
    w_hit     = 1'b0;
    w_hit_sel = '0;
    for (int i = M_COUNT - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit     = 1'b1;
        w_hit_sel = SEL_W'(i);
      end
    end
  end

  assign w_hdr_fire = s_eth_hdr_valid && r_s_hdr_ready;
  assign w_in_fire  = s_eth_payload_axis_tvalid && r_s_payload_tready;
  assign w_fwd_fire = w_in_fire && (r_state == ST_FORWARD);
  assign w_m_tready = m_eth_payload_axis_tready[r_sel];
  assign w_in_tkeep = KEEP_ENABLE ? s_eth_payload_axis_tkeep : {KEEP_WIDTH{1'b1}};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: a frame ends when its tlast beat is accepted on the input
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hdr_fire) begin
          w_state_next = w_hit ? ST_FORWARD : ST_DROP;
        end
      end
      ST_FORWARD, ST_DROP: begin
        if (w_in_fire && s_eth_payload_axis_tlast) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and registers
  always_comb begin
    busy = (r_state != ST_IDLE);
    m_eth_payload_axis_tvalid = '0;
    for (int i = 0; i < M_COUNT; i++) begin
      m_eth_payload_axis_tvalid[i] = r_out_valid && (r_sel == SEL_W'(i));
    end
  end

  // Next values for the header valids, the skid and the registered readys
  always_comb begin
    w_hdr_valid_next = r_hdr_valid & ~m_eth_hdr_ready;
    if (w_hdr_fire && w_hit) begin
      w_hdr_valid_next = M_COUNT'(1) << w_hit_sel;
    end

    w_out_valid_next = r_out_valid;
    w_tmp_valid_next = r_tmp_valid;
    w_load_out_in    = 1'b0;
    w_load_out_tmp   = 1'b0;
    w_load_tmp_in    = 1'b0;
    if ((r_state == ST_FORWARD) && r_s_payload_tready) begin
      if (w_m_tready || !r_out_valid) begin
        w_out_valid_next = s_eth_payload_axis_tvalid;
        w_load_out_in    = 1'b1;
      end else begin
        w_tmp_valid_next = s_eth_payload_axis_tvalid;
        w_load_tmp_in    = 1'b1;
      end
    end else if (w_m_tready) begin
      w_out_valid_next = r_tmp_valid;
      w_tmp_valid_next = 1'b0;
      w_load_out_tmp   = 1'b1;
    end

    // Ready is computed a cycle early; temp absorbs the one beat that arrives late
    w_s_payload_tready_next = 1'b0;
    case (w_state_next)
      ST_FORWARD: w_s_payload_tready_next = w_m_tready ||
                    (!r_tmp_valid && (!r_out_valid || !w_fwd_fire));
      ST_DROP:    w_s_payload_tready_next = 1'b1;
      default:    w_s_payload_tready_next = 1'b0;
    endcase

    // A new header waits until the old header is taken and the skid is empty
    w_s_hdr_ready_next = (w_state_next == ST_IDLE) && (w_hdr_valid_next == '0) &&
                         !w_out_valid_next && !w_tmp_valid_next;
  end

  // Header, skid and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel              <= '0;
      r_hdr_valid        <= '0;
      r_dest_mac         <= '0;
      r_src_mac          <= '0;
      r_eth_type         <= '0;
      r_s_hdr_ready      <= 1'b0;
      r_s_payload_tready <= 1'b0;
      r_drop_frame       <= 1'b0;
      r_out_valid        <= 1'b0;
      r_out_tdata        <= '0;
      r_out_tkeep        <= '0;
      r_out_tlast        <= 1'b0;
      r_out_tuser        <= 1'b0;
      r_tmp_valid        <= 1'b0;
      r_tmp_tdata        <= '0;
      r_tmp_tkeep        <= '0;
      r_tmp_tlast        <= 1'b0;
      r_tmp_tuser        <= 1'b0;
    end else begin
      r_hdr_valid        <= w_hdr_valid_next;
      r_s_hdr_ready      <= w_s_hdr_ready_next;
      r_s_payload_tready <= w_s_payload_tready_next;
      r_drop_frame       <= w_hdr_fire && !w_hit;
      r_out_valid        <= w_out_valid_next;
      r_tmp_valid        <= w_tmp_valid_next;

      if (w_hdr_fire && w_hit) begin
        r_sel      <= w_hit_sel;
        r_dest_mac <= s_eth_dest_mac;
        r_src_mac  <= s_eth_src_mac;
        r_eth_type <= s_eth_type;
      end

      if (w_load_out_in) begin
        r_out_tdata <= s_eth_payload_axis_tdata;
        r_out_tkeep <= w_in_tkeep;
        r_out_tlast <= s_eth_payload_axis_tlast;
        r_out_tuser <= s_eth_payload_axis_tuser;
      end else if (w_load_out_tmp) begin
        r_out_tdata <= r_tmp_tdata;
        r_out_tkeep <= r_tmp_tkeep;
        r_out_tlast <= r_tmp_tlast;
        r_out_tuser <= r_tmp_tuser;
      end

      if (w_load_tmp_in) begin
        r_tmp_tdata <= s_eth_payload_axis_tdata;
        r_tmp_tkeep <= w_in_tkeep;
        r_tmp_tlast <= s_eth_payload_axis_tlast;
        r_tmp_tuser <= s_eth_payload_axis_tuser;
      end
    end
  end

  assign s_eth_hdr_ready           = r_s_hdr_ready;
  assign s_eth_payload_axis_tready = r_s_payload_tready;
  assign m_eth_hdr_valid           = r_hdr_valid;
  assign m_eth_dest_mac            = r_dest_mac;
  assign m_eth_src_mac             = r_src_mac;
  assign m_eth_type                = r_eth_type;
  assign m_eth_payload_axis_tdata  = r_out_tdata;
  assign m_eth_payload_axis_tkeep  = r_out_tkeep;
  assign m_eth_payload_axis_tlast  = r_out_tlast;
  assign m_eth_payload_axis_tuser  = r_out_tuser;
  assign drop_frame                = r_drop_frame;

endmodule

// File: tb/tb_eth_type_classifier.sv
// Scoreboard bench for eth_type_classifier: the driver pushes expected headers
// and beats, and a negedge monitor pops and compares them as the DUT emits.
// A second instance with entry 0 disabled covers the table-enable case.

module tb_eth_type_classifier;

  logic clk;
  logic rst;

  logic        s_hdr_valid;
  logic        use_b;
  logic [47:0] s_dest;
  logic [47:0] s_src;
  logic [15:0] s_type;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tuser;
  logic [3:0]  m_hdr_ready;
  logic [3:0]  m_tready;
  logic        toggle_en;

  logic a_hv, a_tv, b_hv, b_tv;
  assign a_hv = s_hdr_valid & ~use_b;
  assign a_tv = s_tvalid & ~use_b;
  assign b_hv = s_hdr_valid & use_b;
  assign b_tv = s_tvalid & use_b;

  logic        a_s_hdr_ready, a_s_tready, a_tlast, a_tuser, a_busy, a_drop;
  logic [3:0]  a_m_hdr_valid, a_tvalid;
  logic [47:0] a_dest, a_src;
  logic [15:0] a_type;
  logic [63:0] a_tdata;
  logic [7:0]  a_tkeep;

  logic        b_s_hdr_ready, b_s_tready, b_tlast, b_tuser, b_busy, b_drop;
  logic [3:0]  b_m_hdr_valid, b_tvalid;
  logic [47:0] b_dest, b_src;
  logic [15:0] b_type;
  logic [63:0] b_tdata;
  logic [7:0]  b_tkeep;

  eth_type_classifier u_dut (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(a_hv), .s_eth_hdr_ready(a_s_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
    .s_eth_payload_axis_tvalid(a_tv), .s_eth_payload_axis_tready(a_s_tready),
    .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .m_eth_hdr_valid(a_m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(a_dest), .m_eth_src_mac(a_src), .m_eth_type(a_type),
    .m_eth_payload_axis_tdata(a_tdata), .m_eth_payload_axis_tkeep(a_tkeep),
    .m_eth_payload_axis_tvalid(a_tvalid), .m_eth_payload_axis_tready(m_tready),
    .m_eth_payload_axis_tlast(a_tlast), .m_eth_payload_axis_tuser(a_tuser),
    .busy(a_busy), .drop_frame(a_drop)
  );

  eth_type_classifier #(.MATCH_ENABLE(4'b1110)) u_dut_b (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(b_hv), .s_eth_hdr_ready(b_s_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
    .s_eth_payload_axis_tvalid(b_tv), .s_eth_payload_axis_tready(b_s_tready),
    .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .m_eth_hdr_valid(b_m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(b_dest), .m_eth_src_mac(b_src), .m_eth_type(b_type),
    .m_eth_payload_axis_tdata(b_tdata), .m_eth_payload_axis_tkeep(b_tkeep),
    .m_eth_payload_axis_tvalid(b_tvalid), .m_eth_payload_axis_tready(m_tready),
    .m_eth_payload_axis_tlast(b_tlast), .m_eth_payload_axis_tuser(b_tuser),
    .busy(b_busy), .drop_frame(b_drop)
  );

  typedef struct packed {
    logic [2:0]  port;
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] typ;
  } hdr_t;

  typedef struct packed {
    logic [2:0]  port;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  hdr_t  hdr_q[$];
  beat_t beat_q[$];

  int errors = 0;
  int checks = 0;
  int drop_cnt_a = 0;
  int drop_cnt_b = 0;
  logic b_valid_seen = 1'b0;
  logic [3:0] exp_hdr_onehot = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Port 2 payload ready toggles each cycle while enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) m_tready[2] = ~m_tready[2];
    end
  end

  // Monitor: header latency, header/beat scoreboard, drop pulses, input stall
  initial begin
    logic hdr_acc_prev;
    logic [3:0] onehot_prev;
    logic stall_prev;
    hdr_t h;
    beat_t b;
    hdr_acc_prev = 1'b0;
    onehot_prev  = '0;
    stall_prev   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hdr_acc_prev = 1'b0;
        stall_prev   = 1'b0;
      end else begin
        if (hdr_acc_prev) begin
          check("hdr_latency", a_m_hdr_valid, onehot_prev);
          check("drop_pulse", a_drop, (onehot_prev == 4'b0));
        end
        hdr_acc_prev = a_hv && a_s_hdr_ready;
        onehot_prev  = exp_hdr_onehot;

        if (stall_prev) check("input_stall", a_s_tready, 0);
        stall_prev = a_s_tready && a_tv && (a_tvalid != 0) && ((a_tvalid & m_tready) == 0);

        for (int i = 0; i < 4; i++) begin
          if (a_m_hdr_valid[i] && m_hdr_ready[i]) begin
            if (hdr_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL hdr_unexpected: header on port %0d, required none", i);
            end else begin
              h = hdr_q.pop_front();
              check("hdr_port", 64'(i), 64'(h.port));
              check("hdr_dest", a_dest, h.dest);
              check("hdr_src", a_src, h.src);
              check("hdr_type", a_type, h.typ);
              $display("hdr  port=%0d type=%h", i, a_type);
            end
          end
        end

        if (a_tvalid != 0) begin
          if (beat_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat_unexpected: tvalid=%b, required 0000", a_tvalid);
          end else begin
            b = beat_q[0];
            check("beat_port", a_tvalid, 4'b0001 << b.port);
            if ((a_tvalid & m_tready) != 0) begin
              void'(beat_q.pop_front());
              check("beat_data", a_tdata, b.data);
              check("beat_keep", a_tkeep, b.keep);
              check("beat_last", a_tlast, b.last);
              check("beat_user", a_tuser, b.user);
              $display("beat port=%0d data=%h keep=%h last=%0d user=%0d",
                       b.port, a_tdata, a_tkeep, a_tlast, a_tuser);
            end
          end
        end

        if (a_drop) drop_cnt_a++;
        if (b_drop) drop_cnt_b++;
        if ((b_m_hdr_valid != 0) || (b_tvalid != 0)) b_valid_seen = 1'b1;
      end
    end
  end

  // Present one header; port < 0 means the frame is expected to be dropped
  task automatic send_hdr(input logic [15:0] typ, input int port);
    hdr_t h;
    logic ok;
    int n;
    s_type = typ;
    s_dest = {32'hDA0000AA, typ};
    s_src  = {32'h5A0000BB, typ};
    exp_hdr_onehot = (port < 0) ? 4'b0000 : (4'b0001 << port);
    if (port >= 0 && !use_b) begin
      h.port = 3'(port); h.dest = s_dest; h.src = s_src; h.typ = typ;
      hdr_q.push_back(h);
    end
    s_hdr_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = use_b ? b_s_hdr_ready : a_s_hdr_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 500);
    if (!ok) check("hdr_timeout", ok, 1);
    s_hdr_valid = 1'b0;
  endtask

  // Send the first n_send beats of an n_total beat frame
  task automatic send_beats(input int port, input int n_total, input int n_send, input logic [7:0] seed);
    beat_t b;
    logic ok;
    int n;
    for (int i = 0; i < n_send; i++) begin
      s_tdata  = {seed, 8'(i), 16'hBEEF, 32'(i * 17)};
      s_tkeep  = (i == n_total - 1) ? 8'h0F : 8'hFF;
      s_tuser  = (i == 1);
      s_tlast  = (i == n_total - 1);
      s_tvalid = 1'b1;
      if (port >= 0 && !use_b) begin
        b.port = 3'(port); b.data = s_tdata; b.keep = s_tkeep;
        b.last = s_tlast; b.user = s_tuser;
        beat_q.push_back(b);
      end
      n = 0;
      do begin
        @(negedge clk);
        ok = use_b ? b_s_tready : a_s_tready;
        if (port < 0) check("drop_tready", ok, 1);
        @(posedge clk);
        #1;
        n++;
      end while (!ok && n < 500);
      if (!ok) check("beat_timeout", ok, 1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check(name, use_b ? b_busy : a_busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (hdr_q.size() != 0 || beat_q.size() != 0); i++) @(posedge clk);
    #1;
    check("drain_hdr_q", hdr_q.size(), 0);
    check("drain_beat_q", beat_q.size(), 0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; use_b = 1'b0; toggle_en = 1'b0;
    s_hdr_valid = 1'b0; s_dest = '0; s_src = '0; s_type = '0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_hdr_ready = 4'hF; m_tready = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hdr_valid", a_m_hdr_valid, 0);
    check("rst_tvalid", a_tvalid, 0);
    check("rst_hdr_ready", a_s_hdr_ready, 0);
    check("rst_tready", a_s_tready, 0);
    check("rst_busy", a_busy, 0);
    check("rst_drop", a_drop, 0);
    check("rst_type", a_type, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // IPv4 frame to port 0
    send_hdr(16'h0800, 0);
    send_beats(0, 3, 3, 8'h10);
    drain();

    // ARP then IPv6 back-to-back
    send_hdr(16'h0806, 1);
    send_beats(1, 2, 2, 8'h20);
    check_idle("busy_between");
    send_hdr(16'h86DD, 3);
    send_beats(3, 4, 4, 8'h30);
    drain();

    // Unknown type is dropped
    d0 = drop_cnt_a;
    send_hdr(16'h1234, -1);
    send_beats(-1, 4, 4, 8'h40);
    check_idle("busy_after_drop");
    check("drop_count", drop_cnt_a - d0, 1);

    // PTP with port 2 ready toggling
    toggle_en = 1'b1;
    send_hdr(16'h88F7, 2);
    send_beats(2, 8, 8, 8'h50);
    drain();
    toggle_en = 1'b0;
    #1;
    m_tready[2] = 1'b1;

    // Entry 0 disabled on the second instance, then enabled on the first
    use_b = 1'b1;
    send_hdr(16'h0800, -1);
    send_beats(-1, 3, 3, 8'h60);
    check_idle("busy_b_after_drop");
    use_b = 1'b0;
    check("b_drop_count", drop_cnt_b, 1);
    check("b_no_valid", b_valid_seen, 0);
    send_hdr(16'h0800, 0);
    send_beats(0, 3, 3, 8'h70);
    drain();

    // Reset on beat 2 of a 5-beat frame
    send_hdr(16'h0800, 0);
    send_beats(0, 5, 2, 8'h80);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_hdr_valid", a_m_hdr_valid, 0);
    check("mid_rst_tvalid", a_tvalid, 0);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_tready", a_s_tready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_hdr_q", hdr_q.size(), 0);
    check("mid_rst_beat_q", beat_q.size(), 0);
    send_hdr(16'h0806, 1);
    send_beats(1, 3, 3, 8'h90);
    drain();
    check("final_drop_count", drop_cnt_a, 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
